mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Two-master arbiter sharing the single data-bus port that feeds the address decoder,
//   data memory and LED/switch controllers. M0 = core load/store unit, M1 = secondary master (DMA/debug).
//   Round-robin grant, one outstanding transaction, fixed-latency response routed back to the owner.
// PARAMETERS
//   ADDR_W  32  address width
//   DATA_W  32  data width
//   RD_LAT  1   cycles from accepted request to response on s_rdata_i; legal 1..15
// PORTS
//   clk_i        in   1         clock, rising edge
//   rst_ni       in   1         asynchronous reset, active low
//   m0_req_i     in   1         M0 request; held until m0_gnt_o
//   m0_we_i      in   1         M0 write enable
//   m0_addr_i    in   ADDR_W    M0 address
//   m0_wdata_i   in   DATA_W    M0 write data
//   m0_be_i      in   DATA_W/8  M0 byte enables
//   m0_gnt_o     out  1         M0 request accepted this cycle
//   m0_rvalid_o  out  1         M0 response (read data or write ack), 1-cycle pulse
//   m0_rdata_o   out  DATA_W    M0 read data, valid with m0_rvalid_o, else 0
//   m1_*         --   --        identical set for M1 (req/we/addr/wdata/be in; gnt/rvalid/rdata out)
//   s_req_o      out  1         request to decoder
//   s_we_o       out  1         write enable to decoder
//   s_addr_o     out  ADDR_W    address to decoder
//   s_wdata_o    out  DATA_W    write data
//   s_be_o       out  DATA_W/8  byte enables
//   s_rdata_i    in   DATA_W    read data from decoder mux, valid RD_LAT cycles after s_req_o
// BEHAVIOUR
//   - FSM: IDLE, WAIT. Registers: state, owner (1b), last (1b), cnt ($clog2(RD_LAT+1) bits).
//   - Reset (async, rst_ni=0): state=IDLE, owner=0, last=1 (M0 wins first tie), cnt=0.
//     All outputs 0 during and after reset until a request arrives.
//   - IDLE: if any mX_req_i: select winner; only one requester -> it wins; both -> the master != last.
//     Same cycle (combinational): mX_gnt_o=1, s_req_o=1, s_* = winner's we/addr/wdata/be.
//     On clock edge: owner<=winner, last<=winner, cnt<=1, state<=WAIT.
//     No request: s_req_o=0, s_we_o=0, s_addr_o/s_wdata_o/s_be_o=0, gnt both 0.
//   - WAIT: s_req_o=0, s_we_o=0, s_addr_o/s_wdata_o/s_be_o=0, both gnt=0; new requests stall (not dropped, not latched).
//     cnt<RD_LAT: cnt<=cnt+1.
//     cnt==RD_LAT: m<owner>_rvalid_o=1, m<owner>_rdata_o=s_rdata_i (combinational);
//     state<=IDLE next edge. Writes also get rvalid (rdata then don't-care but driven from s_rdata_i).
//   - Non-owner rvalid=0, rdata=0 at all times; owner rdata=0 outside its rvalid cycle.
//   - Throughput: one transaction per RD_LAT+1 cycles; no grant in the rvalid cycle.
//   - Latency: gnt at cycle T, rvalid at T+RD_LAT.
//   - Fairness: continuous requests from both masters alternate M0,M1,M0,...; single requester may win back-to-back.
//   - Reset mid-WAIT: transaction abandoned, no rvalid issued, FSM to IDLE, last=1.
//   - Requester deasserting req while not granted: no effect; grant decision uses current-cycle req only.
//   - Inputs of the winner need only be stable in the grant cycle.
// TESTING
//   1. Reset, M0 read addr 0x0000_0010, RD_LAT=1, mem holds 0xDEAD_BEEF -> m0_gnt_o at T, s_addr_o=0x10 at T,
//      m0_rvalid_o=1 & m0_rdata_o=0xDEAD_BEEF at T+1, m1_rvalid_o stays 0.
//   2. M0 and M1 both request from reset, held -> grants M0 (T), M1 (T+2), M0 (T+4); each rvalid to correct master only.
//   3. M1 write 0x8000_0000 data 0x0000_00A5 be=4'hF -> s_we_o=1, s_addr_o=0x8000_0000, s_wdata_o=0xA5 in grant cycle;
//      m1_rvalid_o pulse next cycle; LED register reads back 0xA5.
//   4. RD_LAT=3: M0 read -> gnt T, rvalid T+3; M1 request raised at T+1 -> gnt not before T+4.
//   5. rst_ni low at T+1 of RD_LAT=3 read -> no rvalid ever for it; after release both req -> M0 granted first.
//   6. No requests for 10 cycles -> all s_* and m*_gnt/rvalid/rdata outputs held at 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single data-bus slave port (address decoder, data memory,
// LED/switch controllers) between two masters:
//   M0 = core load/store unit, M1 = secondary master (DMA/debug).
// Round-robin grant, one transaction in flight at a time, and a fixed
// RD_LAT-cycle response that is routed back to the master that owns it.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width (byte enables are DATA_W/8 wide)
//   RD_LAT  cycles from accepted request to response on s_rdata_i (1..15)
//
// Ports
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   mX_req_i                request, held by the master until mX_gnt_o
//   mX_we_i / mX_addr_i     write enable / address
//   mX_wdata_i / mX_be_i    write data / byte enables
//   mX_gnt_o                request accepted this cycle
//   mX_rvalid_o             one-cycle response pulse (read data or write ack)
//   mX_rdata_o              read data, valid with mX_rvalid_o, otherwise 0
//   s_req_o ... s_be_o      request to the decoder, driven only in the grant cycle
//   s_rdata_i               decoder read data, valid RD_LAT cycles after s_req_o
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_be_o,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;     // master whose transaction is in flight
    logic             last;      // master granted most recently
    logic [CNT_W-1:0] cnt;       // cycles since grant, 1..RD_LAT

    logic any_req;
    logic winner;
    logic accept;

    assign any_req = m0_req_i | m1_req_i;

    // On a tie the master that did not win last time gets the bus;
    // a lone requester always wins, even back-to-back.
    assign winner = (m0_req_i & m1_req_i) ? ~last : m1_req_i;

    assign accept = (state == S_IDLE) & any_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // last resets to M1 so that M0 wins the first tie after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else if (accept) begin
            owner <= winner;
            last  <= winner;
            cnt   <= CNT_W'(1);
        end else if ((state == S_WAIT) && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_next  = state;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        s_req_o     = 1'b0;
        s_we_o      = 1'b0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        s_be_o      = '0;

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = S_WAIT;
                    m0_gnt_o   = ~winner;
                    m1_gnt_o   = winner;
                    s_req_o    = 1'b1;
                    s_we_o     = winner ? m1_we_i    : m0_we_i;
                    s_addr_o   = winner ? m1_addr_i  : m0_addr_i;
                    s_wdata_o  = winner ? m1_wdata_i : m0_wdata_i;
                    s_be_o     = winner ? m1_be_i    : m0_be_i;
                end
            end

            S_WAIT: begin
                // Requests arriving here simply stall; the master keeps
                // req asserted and is arbitrated once we are back in IDLE.
                if (cnt == CNT_LAST) begin
                    state_next = S_IDLE;
                    if (owner) begin
                        m1_rvalid_o = 1'b1;
                        m1_rdata_o  = s_rdata_i;
                    end else begin
                        m0_rvalid_o = 1'b1;
                        m0_rdata_o  = s_rdata_i;
                    end
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Two arbiters side by side: dut0 with RD_LAT=1, dut1 with RD_LAT=3, each
// with its own masters and its own small slave memory (16 words, indexed by
// addr[5:2]). Every cycle, each arbiter's outputs are compared against a
// transaction-level model that tracks absolute cycle numbers: when the bus
// is next free, when the pending response is due and who owns it.
// Directed sequences and a constant vector table cover the listed corner
// cases; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // [dut][master]
    logic        req   [2][2];
    logic        we    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [3:0]  be    [2][2];
    logic        gnt   [2][2];
    logic        rvalid[2][2];
    logic [31:0] rdata [2][2];

    // [dut]
    logic        s_req  [2];
    logic        s_we   [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wdata[2];
    logic [3:0]  s_be   [2];
    logic [31:0] s_rdata[2];

    // Slave stub: memory contents and the word addressed by the last request.
    logic [31:0] mem     [2][16];
    logic [3:0]  stub_idx[2];

    assign s_rdata[0] = mem[0][stub_idx[0]];
    assign s_rdata[1] = mem[1][stub_idx[1]];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(req[0][0]), .m0_we_i(we[0][0]), .m0_addr_i(addr[0][0]),
        .m0_wdata_i(wdata[0][0]), .m0_be_i(be[0][0]), .m0_gnt_o(gnt[0][0]),
        .m0_rvalid_o(rvalid[0][0]), .m0_rdata_o(rdata[0][0]),
        .m1_req_i(req[0][1]), .m1_we_i(we[0][1]), .m1_addr_i(addr[0][1]),
        .m1_wdata_i(wdata[0][1]), .m1_be_i(be[0][1]), .m1_gnt_o(gnt[0][1]),
        .m1_rvalid_o(rvalid[0][1]), .m1_rdata_o(rdata[0][1]),
        .s_req_o(s_req[0]), .s_we_o(s_we[0]), .s_addr_o(s_addr[0]),
        .s_wdata_o(s_wdata[0]), .s_be_o(s_be[0]), .s_rdata_i(s_rdata[0])
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(req[1][0]), .m0_we_i(we[1][0]), .m0_addr_i(addr[1][0]),
        .m0_wdata_i(wdata[1][0]), .m0_be_i(be[1][0]), .m0_gnt_o(gnt[1][0]),
        .m0_rvalid_o(rvalid[1][0]), .m0_rdata_o(rdata[1][0]),
        .m1_req_i(req[1][1]), .m1_we_i(we[1][1]), .m1_addr_i(addr[1][1]),
        .m1_wdata_i(wdata[1][1]), .m1_be_i(be[1][1]), .m1_gnt_o(gnt[1][1]),
        .m1_rvalid_o(rvalid[1][1]), .m1_rdata_o(rdata[1][1]),
        .s_req_o(s_req[1]), .s_we_o(s_we[1]), .s_addr_o(s_addr[1]),
        .s_wdata_o(s_wdata[1]), .s_be_o(s_be[1]), .s_rdata_i(s_rdata[1])
    );

    // ---------------- reference model state ----------------
    int          cyc;
    int          next_free [2];   // first cycle the bus can grant again
    int          resp_at   [2];   // cycle the pending response is due, -1 if none
    bit          last_win  [2];
    bit          resp_owner[2];
    logic [3:0]  resp_idx  [2];
    bit          granted   [2][2];

    // Snapshots of the DUT outputs from the most recent cycle.
    logic        sn_gnt  [2][2];
    logic        sn_rv   [2][2];
    logic [31:0] sn_rdata[2][2];
    logic        sn_sreq [2];
    logic        sn_swe  [2];
    logic [31:0] sn_saddr[2];
    logic [31:0] sn_swdata[2];

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic model_and_check(input int d);
        bit          any;
        bit          w;
        bit          gv;
        bit          rv;
        int          lat;
        logic        e_gnt[2];
        logic        e_rv[2];
        logic [31:0] e_rdata[2];
        logic [3:0]  widx;

        lat = (d == 0) ? LAT0 : LAT1;
        any = req[d][0] || req[d][1];
        w   = (req[d][0] && req[d][1]) ? !last_win[d] : req[d][1];
        gv  = rst_n && any && (cyc >= next_free[d]);
        rv  = rst_n && (cyc == resp_at[d]);

        for (int m = 0; m < 2; m++) begin
            e_gnt[m]   = gv && (int'(w) == m);
            e_rv[m]    = rv && (int'(resp_owner[d]) == m);
            e_rdata[m] = e_rv[m] ? mem[d][resp_idx[d]] : 32'h0;
            check($sformatf("dut%0d m%0d gnt", d, m), 64'(gnt[d][m]), 64'(e_gnt[m]));
            check($sformatf("dut%0d m%0d rvalid", d, m), 64'(rvalid[d][m]), 64'(e_rv[m]));
            check($sformatf("dut%0d m%0d rdata", d, m), 64'(rdata[d][m]), 64'(e_rdata[m]));
            sn_gnt[d][m]   = gnt[d][m];
            sn_rv[d][m]    = rvalid[d][m];
            sn_rdata[d][m] = rdata[d][m];
            granted[d][m]  = e_gnt[m];
        end
        check($sformatf("dut%0d s_req", d), 64'(s_req[d]), 64'(gv));
        check($sformatf("dut%0d s_we", d), 64'(s_we[d]), gv ? 64'(we[d][w]) : 64'h0);
        check($sformatf("dut%0d s_addr", d), 64'(s_addr[d]), gv ? 64'(addr[d][w]) : 64'h0);
        check($sformatf("dut%0d s_wdata", d), 64'(s_wdata[d]), gv ? 64'(wdata[d][w]) : 64'h0);
        check($sformatf("dut%0d s_be", d), 64'(s_be[d]), gv ? 64'(be[d][w]) : 64'h0);
        sn_sreq[d]   = s_req[d];
        sn_swe[d]    = s_we[d];
        sn_saddr[d]  = s_addr[d];
        sn_swdata[d] = s_wdata[d];

        if (!rst_n) begin
            next_free[d] = cyc + 1;
            resp_at[d]   = -1;
            last_win[d]  = 1'b1;
        end else if (gv) begin
            last_win[d]   = w;
            resp_owner[d] = w;
            resp_idx[d]   = addr[d][w][5:2];
            resp_at[d]    = cyc + lat;
            next_free[d]  = cyc + lat + 1;
        end

        // Slave stub reacts to what the DUT actually put on the bus.
        if (s_req[d] === 1'b1) begin
            widx        = s_addr[d][5:2];
            stub_idx[d] = widx;
            if (s_we[d] === 1'b1) begin
                for (int b = 0; b < 4; b++)
                    if (s_be[d][b]) mem[d][widx][8*b +: 8] = s_wdata[d][8*b +: 8];
            end
        end
    endtask

    // One clock cycle: compare at the falling edge, return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_and_check(d);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input int m, input logic w_en,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        req[d][m]   = 1'b1;
        we[d][m]    = w_en;
        addr[d][m]  = a;
        wdata[d][m] = wd;
        be[d][m]    = b;
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0;
                wdata[d][m] = '0; be[d][m] = '0;
            end
    endtask

    task automatic drive_random();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                if (granted[d][m]) req[d][m] = 1'b0;
                if (!req[d][m]) begin
                    if ($urandom_range(2) == 0)
                        set_req(d, m, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
                end else if ($urandom_range(15) == 0) begin
                    req[d][m] = 1'b0;   // give up while still waiting
                end
            end
    endtask

    typedef struct packed {
        bit r0, r1;          // inputs: M0/M1 request
        bit g0, g1, v0, v1;  // expected: grants, response valids
    } vec_t;

    vec_t tbl[6];
    logic quiet;

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        for (int d = 0; d < 2; d++) begin
            next_free[d] = 0; resp_at[d] = -1; last_win[d] = 1'b1;
            resp_owner[d] = 1'b0; resp_idx[d] = '0; stub_idx[d] = '0;
            granted[d][0] = 1'b0; granted[d][1] = 1'b0;
            for (int i = 0; i < 16; i++) mem[d][i] = 32'h1000_0000 * (d + 1) + i;
        end
        clear_all();

        // Both masters held high from reset: M0, M1, M0 with responses one cycle later.
        tbl[0] = '{r0: 1, r1: 1, g0: 1, g1: 0, v0: 0, v1: 0};
        tbl[1] = '{r0: 1, r1: 1, g0: 0, g1: 0, v0: 1, v1: 0};
        tbl[2] = '{r0: 1, r1: 1, g0: 0, g1: 1, v0: 0, v1: 0};
        tbl[3] = '{r0: 1, r1: 1, g0: 0, g1: 0, v0: 0, v1: 1};
        tbl[4] = '{r0: 1, r1: 1, g0: 1, g1: 0, v0: 0, v1: 0};
        tbl[5] = '{r0: 1, r1: 1, g0: 0, g1: 0, v0: 1, v1: 0};

        // Reset.
        @(posedge clk); #1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Ten idle cycles: nothing may move.
        quiet = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            for (int d = 0; d < 2; d++)
                quiet = quiet | sn_sreq[d] | sn_swe[d] | (|sn_saddr[d]) | (|sn_swdata[d])
                      | sn_gnt[d][0] | sn_gnt[d][1] | sn_rv[d][0] | sn_rv[d][1]
                      | (|sn_rdata[d][0]) | (|sn_rdata[d][1]);
        end
        check("idle outputs quiet", 64'(quiet), 64'h0);

        // Round-robin table on dut0.
        addr[0][0] = 32'h0000_0004;
        addr[0][1] = 32'h0000_0008;
        be[0][0] = 4'hF;
        be[0][1] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            req[0][0] = tbl[i].r0;
            req[0][1] = tbl[i].r1;
            cycle();
            check($sformatf("table[%0d] gnt", i), {62'h0, sn_gnt[0][1], sn_gnt[0][0]}, {62'h0, tbl[i].g1, tbl[i].g0});
            check($sformatf("table[%0d] rvalid", i), {62'h0, sn_rv[0][1], sn_rv[0][0]}, {62'h0, tbl[i].v1, tbl[i].v0});
        end
        clear_all();
        cycle();

        // M0 read of 0x10 on dut0.
        mem[0][4] = 32'hDEAD_BEEF;
        set_req(0, 0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        cycle();
        check("read gnt", 64'(sn_gnt[0][0]), 64'h1);
        check("read s_addr", 64'(sn_saddr[0]), 64'h10);
        req[0][0] = 1'b0;
        cycle();
        check("read rvalid", 64'(sn_rv[0][0]), 64'h1);
        check("read rdata", 64'(sn_rdata[0][0]), 64'hDEAD_BEEF);
        check("read m1 rvalid", 64'(sn_rv[0][1]), 64'h0);

        // M1 write to the LED register, then M0 reads it back.
        set_req(0, 1, 1'b1, 32'h8000_0000, 32'h0000_00A5, 4'hF);
        cycle();
        check("write s_we", 64'(sn_swe[0]), 64'h1);
        check("write s_addr", 64'(sn_saddr[0]), 64'h8000_0000);
        check("write s_wdata", 64'(sn_swdata[0]), 64'hA5);
        req[0][1] = 1'b0;
        cycle();
        check("write m1 rvalid", 64'(sn_rv[0][1]), 64'h1);
        check("write m0 rvalid", 64'(sn_rv[0][0]), 64'h0);
        set_req(0, 0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        cycle();
        req[0][0] = 1'b0;
        cycle();
        check("led readback", 64'(sn_rdata[0][0]), 64'hA5);

        // dut1 (RD_LAT=3): M1 arriving during the wait stalls until T+4.
        mem[1][8] = 32'h1111_2222;
        mem[1][9] = 32'h3333_4444;
        set_req(1, 0, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
        cycle();
        check("lat3 gnt T", 64'(sn_gnt[1][0]), 64'h1);
        req[1][0] = 1'b0;
        set_req(1, 1, 1'b0, 32'h0000_0024, 32'h0, 4'hF);
        cycle();
        check("lat3 stall T+1", 64'(sn_gnt[1][1]), 64'h0);
        cycle();
        check("lat3 stall T+2", 64'(sn_gnt[1][1]), 64'h0);
        cycle();
        check("lat3 rvalid T+3", 64'(sn_rv[1][0]), 64'h1);
        check("lat3 rdata T+3", 64'(sn_rdata[1][0]), 64'h1111_2222);
        check("lat3 stall T+3", 64'(sn_gnt[1][1]), 64'h0);
        cycle();
        check("lat3 gnt T+4", 64'(sn_gnt[1][1]), 64'h1);
        req[1][1] = 1'b0;
        cycle();
        cycle();
        cycle();
        check("lat3 m1 rvalid", 64'(sn_rv[1][1]), 64'h1);
        check("lat3 m1 rdata", 64'(sn_rdata[1][1]), 64'h3333_4444);
        cycle();

        // Reset in the middle of a dut1 read: the response is abandoned.
        set_req(1, 0, 1'b0, 32'h0000_0028, 32'h0, 4'hF);
        cycle();
        req[1][0] = 1'b0;
        rst_n = 1'b0;
        quiet = 1'b0;
        cycle();
        quiet = quiet | sn_rv[1][0] | sn_rv[1][1];
        cycle();
        quiet = quiet | sn_rv[1][0] | sn_rv[1][1];
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            quiet = quiet | sn_rv[1][0] | sn_rv[1][1];
        end
        check("abandoned read no rvalid", 64'(quiet), 64'h0);
        set_req(1, 0, 1'b0, 32'h0000_002C, 32'h0, 4'hF);
        set_req(1, 1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        cycle();
        check("post-reset tie", {62'h0, sn_gnt[1][1], sn_gnt[1][0]}, 64'h1);
        req[1][0] = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        cycle();
        check("post-reset m1 gnt", 64'(sn_gnt[1][1]), 64'h1);
        req[1][1] = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic on both arbiters against the model.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end
        clear_all();
        for (int i = 0; i < 6; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
